// File: rtl/sc_elastic_pipe.sv
// Bubble-collapsing WIDTH x DEPTH register pipeline with valid/ready flow
// control, occupancy count and a full-chain scan mode.
module sc_elastic_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         VDD,
    input  logic                         VSS,
    input  logic                         VPW,
    input  logic                         VNW,
    input  logic                         IN_VALID,
    output logic                         IN_READY,
    input  logic [WIDTH-1:0]             IN_DATA,
    output logic                         OUT_VALID,
    input  logic                         OUT_READY,
    output logic [WIDTH-1:0]             OUT_DATA,
    input  logic                         SE,
    input  logic                         SI,
    output logic                         SO,
    output logic [$clog2(DEPTH+1)-1:0]   COUNT
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][WIDTH-1:0] d;
    logic [DEPTH-1:0][WIDTH-1:0] d_next;
    logic [DEPTH-1:0]            v;
    logic [DEPTH-1:0]            v_next;
    logic [DEPTH-1:0]            mv;
    logic [DEPTH*WIDTH-1:0]      chain;
    logic [DEPTH*WIDTH-1:0]      shifted;
    logic                        run;
    logic                        in_xfer;
    logic                        unused_supply;

    assign unused_supply = ^{VDD, VSS, VPW, VNW};

    assign run = ~SE & ~RST;

    // Move permission ripples from the output stage back toward the input,
    // so a stage may advance into a slot that is being vacated this cycle.
    always_comb begin : advance
        logic go;
        go = v[DEPTH-1] & OUT_READY & run;
        mv = '0;
        mv[DEPTH-1] = go;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            go = v[DEPTH-1-i] & (~v[DEPTH-i] | go) & run;
            mv[DEPTH-1-i] = go;
        end
    end

    assign IN_READY  = run & (~v[0] | mv[0]);
    assign in_xfer   = IN_VALID & IN_READY;
    assign OUT_VALID = v[DEPTH-1] & run;
    assign OUT_DATA  = d[DEPTH-1];
    assign SO        = d[DEPTH-1][WIDTH-1];

    // Scan chain order: SI -> d[0][0] .. d[0][WIDTH-1] -> d[1][0] .. -> SO.
    assign chain = d;

    always_comb begin
        shifted    = '0;
        shifted[0] = SI;
        for (int unsigned i = 1; i < DEPTH * WIDTH; i++) begin
            shifted[i] = chain[i-1];
        end
    end

    always_comb begin
        v_next = v;
        d_next = d;
        if (SE) begin
            d_next = shifted;
        end else begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (mv[k]) begin
                    v_next[k] = 1'b0;
                end
            end
            if (in_xfer) begin
                v_next[0] = 1'b1;
                d_next[0] = IN_DATA;
            end
            for (int unsigned k = 1; k < DEPTH; k++) begin
                if (mv[k-1]) begin
                    v_next[k] = 1'b1;
                    d_next[k] = d[k-1];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            v <= '0;
            d <= '0;
        end else begin
            v <= v_next;
            d <= d_next;
        end
    end

    always_comb begin
        COUNT = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            COUNT = COUNT + CW'(v[k]);
        end
    end

endmodule

// File: tb/tb_sc_elastic_pipe.sv
// Scoreboard bench for sc_elastic_pipe (WIDTH=8, DEPTH=4): accepted inputs are
// queued, every output transfer is checked against the queue head.
module tb_sc_elastic_pipe;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       in_valid  = 1'b0;
    logic       out_ready = 1'b0;
    logic       se        = 1'b0;
    logic       si        = 1'b0;
    logic [7:0] in_data   = '0;
    logic       in_ready;
    logic       out_valid;
    logic       so;
    logic [7:0] out_data;
    logic [2:0] count;

    logic [7:0] sb[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sc_elastic_pipe #(.WIDTH(8), .DEPTH(4)) dut (
        .CLK(clk), .RST(rst),
        .VDD(1'b1), .VSS(1'b0), .VPW(1'b0), .VNW(1'b1),
        .IN_VALID(in_valid), .IN_READY(in_ready), .IN_DATA(in_data),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_DATA(out_data),
        .SE(se), .SI(si), .SO(so), .COUNT(count)
    );

    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_extra_output got %02h required no output", out_data);
            end else begin
                if (out_data !== sb[0]) begin
                    errors++;
                    $display("FAIL sb_order got %02h required %02h", out_data, sb[0]);
                end
                void'(sb.pop_front());
            end
        end
        if (in_valid === 1'b1 && in_ready === 1'b1) sb.push_back(in_data);
    end

    task automatic drain(input int max_cycles);
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (sb.size() != 0 && n < max_cycles) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got %0d items left required 0", sb.size());
        end
        @(negedge clk);
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty got count=%0d out_valid=%b required 0 0", count, out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1; se = 1'b0; si = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0) begin
                errors++; $display("FAIL reset_in_ready got %b required 0", in_ready);
            end
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL reset_out_valid got %b required 0", out_valid);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0; in_valid = 1'b0; in_data = '0;
        sb.delete();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid got %b required 0", out_valid); end
        checks++;
        if (out_data !== 8'h00) begin errors++; $display("FAIL post_reset_out_data got %02h required 00", out_data); end
        checks++;
        if (so !== 1'b0) begin errors++; $display("FAIL post_reset_so got %b required 0", so); end
        checks++;
        if (count !== 3'd0) begin errors++; $display("FAIL post_reset_count got %0d required 0", count); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b required 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_latency_stream();
        logic exp_ov;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL latency_in_ready got %b required 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exp_ov = (k == 3);
            checks++;
            if (out_valid !== exp_ov) begin
                errors++; $display("FAIL latency_out_valid edge+%0d got %b required %b", k, out_valid, exp_ov);
            end
            if (k < 3) @(posedge clk);
        end
        checks++;
        if (out_data !== 8'hA5) begin errors++; $display("FAIL latency_out_data got %02h required a5", out_data); end
        @(posedge clk); #1;
        for (int t = 0; t < 24; t++) begin
            in_valid = (t < 16);
            in_data  = 8'(t + 1);
            @(negedge clk);
            exp_ov = (t >= 4 && t < 20);
            checks++;
            if (out_valid !== exp_ov) begin
                errors++; $display("FAIL stream_out_valid t=%0d got %b required %b", t, out_valid, exp_ov);
            end
            if (exp_ov) begin
                checks++;
                if (out_data !== 8'(t - 3)) begin
                    errors++; $display("FAIL stream_out_data t=%0d got %02h required %02h", t, out_data, 8'(t - 3));
                end
            end
            if (t < 16) begin
                checks++;
                if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready t=%0d got %b required 1", t, in_ready); end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        int idx = 0;
        logic exp_rdy;
        out_ready = 1'b0;
        for (int t = 0; t < 6; t++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h31 + idx);
            @(negedge clk);
            exp_rdy = (t < 4);
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++; $display("FAIL bp_in_ready t=%0d got %b required %b", t, in_ready, exp_rdy);
            end
            checks++;
            if (count !== 3'((t < 4) ? t : 4)) begin
                errors++; $display("FAIL bp_count t=%0d got %0d required %0d", t, count, (t < 4) ? t : 4);
            end
            if (in_ready === 1'b1) idx++;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int t = 0; t < 8; t++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h31 + idx);
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_flow_in_ready t=%0d got %b required 1", t, in_ready); end
            checks++;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_flow_out_valid t=%0d got %b required 1", t, out_valid); end
            checks++;
            if (count !== 3'd4) begin errors++; $display("FAIL bp_flow_count t=%0d got %0d required 4", t, count); end
            if (in_ready === 1'b1) idx++;
            @(posedge clk); #1;
        end
        drain(12);
    endtask

    task automatic test_bubble_collapse();
        out_ready = 1'b0;
        for (int c = 0; c < 7; c++) begin
            in_valid = (c == 0 || c == 3);
            in_data  = (c == 0) ? 8'h11 : 8'h22;
            @(negedge clk);
            if (c == 0 || c == 3) begin
                checks++;
                if (in_ready !== 1'b1) begin errors++; $display("FAIL bubble_in_ready c=%0d got %b required 1", c, in_ready); end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (count !== 3'd2) begin errors++; $display("FAIL bubble_count got %0d required 2", count); end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h11) begin
            errors++; $display("FAIL bubble_head got %b/%02h required 1/11", out_valid, out_data);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h11) begin
            errors++; $display("FAIL bubble_first got %b/%02h required 1/11", out_valid, out_data);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h22) begin
            errors++; $display("FAIL bubble_second got %b/%02h required 1/22", out_valid, out_data);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            errors++; $display("FAIL bubble_empty got %b/%0d required 0/0", out_valid, count);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_scan();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h00;
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL scan_load_in_ready i=%0d got %b required 1", i, in_ready); end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        se = 1'b1; si = 1'b1; in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            checks++;
            if (so !== 1'b0) begin errors++; $display("FAIL scan_so_zero i=%0d got %b required 0", i, so); end
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                errors++; $display("FAIL scan_frozen i=%0d got %b/%b required 0/0", i, in_ready, out_valid);
            end
            checks++;
            if (count !== 3'd4) begin errors++; $display("FAIL scan_count i=%0d got %0d required 4", i, count); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (so !== 1'b1) begin errors++; $display("FAIL scan_so_one got %b required 1", so); end
        checks++;
        if (count !== 3'd4) begin errors++; $display("FAIL scan_count_end got %0d required 4", count); end
        @(posedge clk); #1;
        se = 1'b0; si = 1'b0; in_valid = 1'b0;
        foreach (sb[i]) sb[i] = 8'hFF;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hFF) begin
            errors++; $display("FAIL scan_resume got %b/%02h required 1/ff", out_valid, out_data);
        end
        @(posedge clk); #1;
        drain(10);
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h40 + i);
            @(negedge clk);
            @(posedge clk); #1;
        end
        in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b1; rst = 1'b1;
        sb.delete();
        @(negedge clk);
        checks++;
        if (count !== 3'd3) begin errors++; $display("FAIL rstmid_count_before got %0d required 3", count); end
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_handshake got %b/%b required 0/0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || count !== 3'd0) begin
                errors++; $display("FAIL rstmid_after i=%0d got %b/%0d required 0/0", i, out_valid, count);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_latency_stream();
        test_backpressure();
        test_bubble_collapse();
        test_scan();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sc_elastic_pipe.md
# sc_elastic_pipe

Parametrised, bubble-collapsing register pipeline. Successor to the library's plain D flip-flop: WIDTH-bit data across DEPTH stages, with synchronous reset, valid/ready flow control, an occupancy count and a full-chain scan mode. It is the standard retiming/buffering slice placed between sub-blocks built on this 7-track 3.3 V cell set.

## Interface
- WIDTH, 8, data bits per stage (≥1)
- DEPTH, 4, number of register stages (≥1)

- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset, synchronous, active-high; priority over every other input
- VDD, VSS, VPW, VNW  in  1 each  supply/well pins; no functional effect
- IN_VALID  in  1  upstream item present
- IN_READY  out  1  block accepts IN_DATA this cycle
- IN_DATA  in  WIDTH  upstream data
- OUT_VALID  out  1  OUT_DATA holds a valid item
- OUT_READY  in  1  downstream accepts this cycle
- OUT_DATA  out  WIDTH  data of last stage (DEPTH-1)
- SE  in  1  scan enable
- SI  in  1  scan serial in
- SO  out  1  scan serial out
- COUNT  out  $clog2(DEPTH+1)  number of valid stages

## Operation
- State: per stage k (0..DEPTH-1) a WIDTH-bit data register d[k] and a valid bit v[k]. Stage 0 is the input, stage DEPTH-1 the output.
- Reset (RST=1 at an edge): all v[k]=0 and all d[k]=0. While RST=1, IN_READY=0 and OUT_VALID=0. The scan input is ignored.
- Advance rule: adv[DEPTH-1] = v[DEPTH-1] & OUT_READY. For k<DEPTH-1, stage k moves to k+1 when v[k] & (!v[k+1] | adv[k+1]).
- Bubbles collapse: an item moves forward whenever the next stage is empty, even if the output is stalled.
- IN_READY = !SE & !RST & (!v[0] | v[0] moves forward this cycle). An input transfer is IN_VALID & IN_READY; it writes d[0] and sets v[0].
- OUT_VALID = v[DEPTH-1] & !SE & !RST. An output transfer is OUT_VALID & OUT_READY.
- OUT_DATA always shows d[DEPTH-1], including when it is not valid.
- Ordering is strictly FIFO. No item is duplicated or dropped, except items flushed by RST.
- COUNT = popcount(v). It updates on the edge, with the in and out transfers of the same cycle netted.
- Scan (SE=1, RST=0):
  - Handshakes are frozen and v[] holds.
  - The data registers form one chain of WIDTH·DEPTH bits that shifts one bit per edge: SI → d[0][0] → d[0][1] … → d[0][WIDTH-1] → d[1][0] … → d[DEPTH-1][WIDTH-1].
  - SO = d[DEPTH-1][WIDTH-1] in both modes.
  - When SE drops, normal operation resumes with the scanned data and the held valid bits.

## Timing
- An item accepted at edge n into an empty pipe is visible on OUT_DATA/OUT_VALID after edge n+DEPTH-1. Latency is DEPTH edges including the accepting one; DEPTH=1 gives a single register slice.
- Throughput is one item per cycle, sustained, with OUT_READY=1.
- IN_READY depends combinationally on OUT_READY through the advance chain. When the pipe is full and OUT_READY=1, IN_READY=1 in the same cycle.
- Full (COUNT=DEPTH) with OUT_READY=0: IN_READY=0 and nothing moves.
- Empty: OUT_VALID=0 and IN_READY=1 (when SE=0, RST=0).
- RST asserted mid-stream: any transfer presented in that cycle is discarded. After the edge, COUNT=0 and OUT_VALID=0.
- SE asserted mid-stream: no transfer occurs in any SE=1 cycle, and COUNT is unchanged.
- Reset values: IN_READY=1 (after RST falls), OUT_VALID=0, OUT_DATA=0, SO=0, COUNT=0.

## Test plan
- Reset: hold RST=1 for 2 cycles with IN_VALID=1 and IN_DATA=0xFF -> IN_READY=0 during RST. After release: OUT_VALID=0, OUT_DATA=0x00, SO=0, COUNT=0, IN_READY=1.
- Latency and streaming (WIDTH=8, DEPTH=4, OUT_READY=1): accept 0xA5 at edge n -> OUT_VALID=1 with 0xA5 after edge n+3. Then stream 0x01..0x10 back-to-back -> 16 contiguous outputs, in order, one per cycle.
- Backpressure: OUT_READY=0 with 6 items offered -> 4 accepted, IN_READY=0, COUNT=4. Then OUT_READY=1 with IN_VALID=1 -> one item in and one out per cycle, COUNT stays 4, order preserved.
- Bubble collapse: OUT_READY=0; offer 0x11, idle 2 cycles, offer 0x22 -> both occupy stages 3 and 2, COUNT=2. Then OUT_READY=1 -> 0x11 then 0x22 on consecutive cycles.
- Scan: load 0x00 into all stages, set SE=1, shift in 32 ones -> SO shows 0 for the first 32 cycles, then 1. Handshakes frozen, COUNT held. After SE=0, each valid stage emits 0xFF.
- Reset mid-operation: COUNT=3 and OUT_READY=1, assert RST with IN_VALID=1 and 0x5A -> after the edge COUNT=0 and OUT_VALID=0. 0x5A is never emitted.
